// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS-subset control FSM with retired-instruction counter
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src_b,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RESET  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        I_ILL, I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL
    } instr_t;

    state_t cur, nxt;
    instr_t icls;
    logic   alu_src_b_i;
    logic [1:0] ext_op_i, alu_op_i;
    logic   retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_RESET;
        end else begin
            cur <= nxt;
        end
    end

    // The counter shares the asynchronous reset so a mid-instruction reset
    // clears it together with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt <= '0;
        end else if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign retire = (nxt == S_FETCH) && (cur != S_FETCH) && (cur != S_RESET);
    assign state  = cur;

    always_comb begin
        icls = I_ILL;
        case (opcode)
            6'b000000: begin
                case (func)
                    6'b100001: icls = I_ADDU;
                    6'b100011: icls = I_SUBU;
                    6'b001000: icls = I_JR;
                    6'b000000: icls = I_NOP;
                    default:   icls = I_ILL;
                endcase
            end
            6'b001101: icls = I_ORI;
            6'b001111: icls = I_LUI;
            6'b100011: icls = I_LW;
            6'b101011: icls = I_SW;
            6'b000100: icls = I_BEQ;
            6'b000011: icls = I_JAL;
            default:   icls = I_ILL;
        endcase
    end

    // ALU setup per instruction; driven in EXEC and held through MEM and WB
    // so the datapath result stays stable until it is consumed.
    always_comb begin
        alu_src_b_i = 1'b0;
        ext_op_i    = 2'd0;
        alu_op_i    = 2'd0;
        case (icls)
            I_SUBU, I_BEQ: alu_op_i = 2'd1;
            I_ORI: begin
                alu_op_i    = 2'd2;
                alu_src_b_i = 1'b1;
            end
            I_LUI: begin
                alu_op_i    = 2'd2;
                alu_src_b_i = 1'b1;
                ext_op_i    = 2'd2;
            end
            I_LW, I_SW: begin
                alu_src_b_i = 1'b1;
                ext_op_i    = 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npc_sel   = 2'd0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        alu_src_b = 1'b0;
        ext_op    = 2'd0;
        alu_op    = 2'd0;
        illegal   = 1'b0;
        case (cur)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt = S_FETCH;
                case (icls)
                    I_JAL: begin
                        pc_we   = 1'b1;
                        npc_sel = 2'd2;
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                    I_JR: begin
                        pc_we   = 1'b1;
                        npc_sel = 2'd3;
                    end
                    I_NOP: ;
                    I_ILL: illegal = 1'b1;
                    default: nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_src_b = alu_src_b_i;
                ext_op    = ext_op_i;
                alu_op    = alu_op_i;
                case (icls)
                    I_BEQ: begin
                        nxt = S_FETCH;
                        if (zero) begin
                            pc_we   = 1'b1;
                            npc_sel = 2'd1;
                        end
                    end
                    I_LW, I_SW: nxt = S_MEM;
                    default:    nxt = S_WB;
                endcase
            end
            S_MEM: begin
                alu_src_b = alu_src_b_i;
                ext_op    = ext_op_i;
                alu_op    = alu_op_i;
                mem_req   = 1'b1;
                mem_we    = (icls == I_SW);
                if (mem_ready) begin
                    nxt = (icls == I_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                alu_src_b = alu_src_b_i;
                ext_op    = ext_op_i;
                alu_op    = alu_op_i;
                reg_we    = 1'b1;
                nxt       = S_FETCH;
                case (icls)
                    I_ADDU, I_SUBU: reg_dst = 2'd1;
                    I_LW:           wd_sel  = 2'd1;
                    default: ;
                endcase
            end
            default: nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode, func;
    logic        zero, mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op, alu_op;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    typedef struct packed {
        logic [2:0]  st;
        logic        mem_req, mem_we, ir_we, pc_we;
        logic [1:0]  npc_sel;
        logic        reg_we;
        logic [1:0]  reg_dst, wd_sel;
        logic        alu_src_b;
        logic [1:0]  ext_op, alu_op;
        logic        illegal;
        logic [31:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .alu_op(alu_op), .state(state), .illegal(illegal),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int st, int mreq, int mwe, int irwe, int pcwe, int npc,
                                int rwe, int rdst, int wds, int asb, int ext, int aop,
                                int ill, int cnt);
        obs_t o;
        o.st = 3'(st);         o.mem_req = 1'(mreq); o.mem_we = 1'(mwe);
        o.ir_we = 1'(irwe);    o.pc_we = 1'(pcwe);   o.npc_sel = 2'(npc);
        o.reg_we = 1'(rwe);    o.reg_dst = 2'(rdst); o.wd_sel = 2'(wds);
        o.alu_src_b = 1'(asb); o.ext_op = 2'(ext);   o.alu_op = 2'(aop);
        o.illegal = 1'(ill);   o.cnt = 32'(cnt);
        return o;
    endfunction

    function automatic obs_t fe(int c);  // FETCH, memory ready
        return mk(0, 1,0,1,1,0, 0,0,0, 0,0,0, 0, c);
    endfunction
    function automatic obs_t fs(int c);  // FETCH, memory stalled
        return mk(0, 1,0,0,0,0, 0,0,0, 0,0,0, 0, c);
    endfunction
    function automatic obs_t de(int c);  // DECODE, no controls
        return mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, c);
    endfunction
    function automatic obs_t rs();
        return mk(7, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0);
    endfunction

    task automatic cyc(input logic rst, input logic mr, input logic z, input obs_t e);
        reset_n   = rst;
        mem_ready = mr;
        zero      = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        func   = fn;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            obs_t e, a;
            e = sb.pop_front();
            a = '{st:state, mem_req:mem_req, mem_we:mem_we, ir_we:ir_we, pc_we:pc_we,
                  npc_sel:npc_sel, reg_we:reg_we, reg_dst:reg_dst, wd_sel:wd_sel,
                  alu_src_b:alu_src_b, ext_op:ext_op, alu_op:alu_op,
                  illegal:illegal, cnt:instr_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t state=%0d act=%h exp=%h", $time, e.st, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        ins(6'b000000, 6'b000000);
        @(posedge clk); #1;
        cyc(0, 0, 0, rs());
        cyc(1, 0, 0, rs());

        // addu: 0,1,2,4 then FETCH with count 1
        ins(6'b000000, 6'b100001);
        cyc(1, 1, 0, fe(0));
        cyc(1, 1, 0, de(0));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0));
        cyc(1, 1, 0, mk(4, 0,0,0,0,0, 1,1,0, 0,0,0, 0, 0));

        // lw with two wait cycles in MEM: 7 cycles total
        ins(6'b100011, 6'b000000);
        cyc(1, 1, 0, fe(1));
        cyc(1, 1, 0, de(1));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 1,1,0, 0, 1));
        cyc(1, 0, 0, mk(3, 1,0,0,0,0, 0,0,0, 1,1,0, 0, 1));
        cyc(1, 0, 0, mk(3, 1,0,0,0,0, 0,0,0, 1,1,0, 0, 1));
        cyc(1, 1, 0, mk(3, 1,0,0,0,0, 0,0,0, 1,1,0, 0, 1));
        cyc(1, 1, 0, mk(4, 0,0,0,0,0, 1,0,1, 1,1,0, 0, 1));

        // beq taken then not taken
        ins(6'b000100, 6'b000000);
        cyc(1, 1, 0, fe(2));
        cyc(1, 1, 0, de(2));
        cyc(1, 1, 1, mk(2, 0,0,0,1,1, 0,0,0, 0,0,1, 0, 2));
        cyc(1, 1, 0, fe(3));
        cyc(1, 1, 0, de(3));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 0,0,1, 0, 3));

        // jal
        ins(6'b000011, 6'b000000);
        cyc(1, 1, 0, fe(4));
        cyc(1, 1, 0, mk(1, 0,0,0,1,2, 1,2,2, 0,0,0, 0, 4));

        // illegal opcode after a stalled fetch
        ins(6'b111111, 6'b000000);
        cyc(1, 0, 0, fs(5));
        cyc(1, 1, 0, fe(5));
        cyc(1, 1, 0, mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 1, 5));

        // nop
        ins(6'b000000, 6'b000000);
        cyc(1, 1, 0, fe(6));
        cyc(1, 1, 0, de(6));

        // jr
        ins(6'b000000, 6'b001000);
        cyc(1, 1, 0, fe(7));
        cyc(1, 1, 0, mk(1, 0,0,0,1,3, 0,0,0, 0,0,0, 0, 7));

        // ori
        ins(6'b001101, 6'b000000);
        cyc(1, 1, 0, fe(8));
        cyc(1, 1, 0, de(8));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 1,0,2, 0, 8));
        cyc(1, 1, 0, mk(4, 0,0,0,0,0, 1,0,0, 1,0,2, 0, 8));

        // lui
        ins(6'b001111, 6'b000000);
        cyc(1, 1, 0, fe(9));
        cyc(1, 1, 0, de(9));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 1,2,2, 0, 9));
        cyc(1, 1, 0, mk(4, 0,0,0,0,0, 1,0,0, 1,2,2, 0, 9));

        // subu
        ins(6'b000000, 6'b100011);
        cyc(1, 1, 0, fe(10));
        cyc(1, 1, 0, de(10));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 0,0,1, 0, 10));
        cyc(1, 1, 0, mk(4, 0,0,0,0,0, 1,1,0, 0,0,1, 0, 10));

        // R-type with unsupported func
        ins(6'b000000, 6'b111111);
        cyc(1, 1, 0, fe(11));
        cyc(1, 1, 0, mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 1, 11));

        // sw, reset dropped between edges while MEM is waiting
        ins(6'b101011, 6'b000000);
        cyc(1, 1, 0, fe(12));
        cyc(1, 1, 0, de(12));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 1,1,0, 0, 12));
        cyc(1, 0, 0, mk(3, 1,1,0,0,0, 0,0,0, 1,1,0, 0, 12));
        cyc(0, 0, 0, rs());
        cyc(1, 1, 0, rs());
        cyc(1, 1, 0, fe(0));
        cyc(1, 1, 0, de(0));
        cyc(1, 1, 0, mk(2, 0,0,0,0,0, 0,0,0, 1,1,0, 0, 0));

        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain act=%0d entries left exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
